rtc_timekeeper: RTL and testbench

Timekeeping core that consumes the adjust block's outputs (adjust_time_num, adjust_date_num, adjust_clock_num) and produces the live time_num/date_num buses that the adjust block copies from.
- Generates a 1 Hz tick from clk and runs a BCD hh:mm:ss / yy-mm-dd calendar with month lengths and leap years.
- Reloads from the adjust buses when calibration mode ends.
- Compares time against the alarm setting and drives a timed alarm output.

---
 rtl/rtc_pkg.sv | 41 ++++
 rtl/rtc_days_in_month.sv | 19 +
 rtl/rtc_timekeeper.sv | 142 ++++++++++++++
 tb/tb_rtc_timekeeper.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared mode encodings, BCD bus field positions and calendar helpers for the RTC.
package rtc_pkg;

  localparam logic [1:0] MODEL_CLOCK     = 2'b00;
  localparam logic [1:0] MODEL_ALARM     = 2'b01;
  localparam logic [1:0] MODEL_STOPWATCH = 2'b10;
  localparam logic [1:0] MODEL_ADJUST    = 2'b11;

  // Byte fields of the 24-bit time bus {hh,mm,ss} and date bus {yy,mo,dd}.
  localparam int HOUR_HI = 23;
  localparam int HOUR_LO = 16;
  localparam int MIN_HI  = 15;
  localparam int MIN_LO  = 8;
  localparam int SEC_HI  = 7;
  localparam int SEC_LO  = 0;
  localparam int YEAR_HI = 23;
  localparam int YEAR_LO = 16;
  localparam int MON_HI  = 15;
  localparam int MON_LO  = 8;
  localparam int DAY_HI  = 7;
  localparam int DAY_LO  = 0;

  typedef enum logic {StIdle, StRing} alarm_state_e;

  // Divisible by 4 without binary conversion: tens parity selects the valid units digits.
  function automatic logic bcd_is_leap(input logic [3:0] y1, input logic [3:0] y0);
    return (!y1[0] && (y0 == 4'd0 || y0 == 4'd4 || y0 == 4'd8)) ||
           ( y1[0] && (y0 == 4'd2 || y0 == 4'd6));
  endfunction

  // Two-digit BCD increment returning {carry, next}; wraps from last to first.
  function automatic logic [8:0] bcd_step(input logic [7:0] v, input logic [7:0] last,
                                          input logic [7:0] first);
    logic [8:0] r;
    if (v == last)            r = {1'b1, first};
    else if (v[3:0] == 4'd9)  r = {1'b0, v[7:4] + 4'd1, 4'd0};
    else                      r = {1'b0, v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/rtc_days_in_month.sv
// Combinational month length in BCD for a BCD month/year pair.
module rtc_days_in_month
  import rtc_pkg::*;
(
  input  logic [7:0] month_i,
  input  logic [7:0] year_i,
  output logic [7:0] days_o
);

  always_comb begin
    days_o = 8'h31;
    case (month_i)
      8'h02:                      days_o = bcd_is_leap(year_i[7:4], year_i[3:0]) ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: days_o = 8'h30;
      default:                    days_o = 8'h31;
    endcase
  end

endmodule

// File: rtl/rtc_timekeeper.sv
// 1 Hz prescaler, BCD time/calendar counters, calibrate reload and timed alarm output.
module rtc_timekeeper
  import rtc_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ    = 50_000_000,
  parameter int unsigned ALARM_RING_SEC = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  model,
  input  logic [23:0] adjust_time_num,
  input  logic [23:0] adjust_date_num,
  input  logic [15:0] adjust_clock_num,
  input  logic        alarm_stop,
  output logic [23:0] time_num,
  output logic [23:0] date_num,
  output logic        sec_tick,
  output logic        alarm_ring
);

  localparam int unsigned PresW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam int unsigned RingW = (ALARM_RING_SEC > 0) ? $clog2(ALARM_RING_SEC + 1) : 1;
  localparam logic [PresW-1:0] PresMax  = PresW'(CLK_FREQ_HZ - 1);
  localparam logic [RingW-1:0] RingInit = RingW'(ALARM_RING_SEC);

  logic [PresW-1:0] cnt_q, cnt_d;
  logic [1:0]       model_q;  // model as sampled on the previous edge
  logic [23:0]      time_q, time_d, date_q, date_d;
  alarm_state_e     state_q, state_d;
  logic [RingW-1:0] ring_q, ring_d;

  logic       calib, load, tick, match;
  logic [7:0] sec_n, min_n, hour_n, day_n, mon_n, year_n;
  logic       c_sec, c_min, c_hour, c_day, c_mon, c_year;
  logic [7:0] dim_cur, dim_adj, adj_month, adj_day;

  assign calib = (model == MODEL_ADJUST);
  assign load  = (model_q == MODEL_ADJUST) && !calib;
  assign tick  = (cnt_q == PresMax) && !calib && !load;

  rtc_days_in_month u_dim_cur (
    .month_i (date_q[MON_HI:MON_LO]),
    .year_i  (date_q[YEAR_HI:YEAR_LO]),
    .days_o  (dim_cur)
  );

  rtc_days_in_month u_dim_adj (
    .month_i (adj_month),
    .year_i  (adjust_date_num[YEAR_HI:YEAR_LO]),
    .days_o  (dim_adj)
  );

  always_comb begin
    adj_month = adjust_date_num[MON_HI:MON_LO];
    if (adj_month == 8'h00)     adj_month = 8'h01;
    else if (adj_month > 8'h12) adj_month = 8'h12;
  end

  always_comb begin
    adj_day = adjust_date_num[DAY_HI:DAY_LO];
    if (adj_day == 8'h00)      adj_day = 8'h01;
    else if (adj_day > dim_adj) adj_day = dim_adj;
  end

  // Ripple carry through the BCD fields; each stage only steps when the one below wrapped.
  always_comb begin
    {c_sec, sec_n} = bcd_step(time_q[SEC_HI:SEC_LO], 8'h59, 8'h00);
    {c_min, min_n} = c_sec ? bcd_step(time_q[MIN_HI:MIN_LO], 8'h59, 8'h00)
                           : {1'b0, time_q[MIN_HI:MIN_LO]};
    {c_hour, hour_n} = c_min ? bcd_step(time_q[HOUR_HI:HOUR_LO], 8'h23, 8'h00)
                             : {1'b0, time_q[HOUR_HI:HOUR_LO]};
    {c_day, day_n} = c_hour ? bcd_step(date_q[DAY_HI:DAY_LO], dim_cur, 8'h01)
                            : {1'b0, date_q[DAY_HI:DAY_LO]};
    {c_mon, mon_n} = c_day ? bcd_step(date_q[MON_HI:MON_LO], 8'h12, 8'h01)
                           : {1'b0, date_q[MON_HI:MON_LO]};
    {c_year, year_n} = c_mon ? bcd_step(date_q[YEAR_HI:YEAR_LO], 8'h99, 8'h00)
                             : {1'b0, date_q[YEAR_HI:YEAR_LO]};
  end

  assign match = tick && ({hour_n, min_n, sec_n} == {adjust_clock_num, 8'h00});

  always_comb begin
    cnt_d   = cnt_q + PresW'(1);
    time_d  = time_q;
    date_d  = date_q;
    state_d = state_q;
    ring_d  = ring_q;

    if (calib || load || cnt_q == PresMax) cnt_d = '0;

    if (load) begin
      time_d = adjust_time_num;
      date_d = {adjust_date_num[YEAR_HI:YEAR_LO], adj_month, adj_day};
    end else if (tick) begin
      time_d = {hour_n, min_n, sec_n};
      date_d = {year_n, mon_n, day_n};
    end

    if (alarm_stop) begin
      state_d = StIdle;
      ring_d  = '0;
    end else if (match) begin
      state_d = StRing;
      ring_d  = RingInit;
    end else if (tick && state_q == StRing) begin
      if (ring_q <= RingW'(1)) begin
        state_d = StIdle;
        ring_d  = '0;
      end else begin
        ring_d = ring_q - RingW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      model_q <= MODEL_CLOCK;
      time_q  <= 24'h000000;
      date_q  <= 24'h000101;
      state_q <= StIdle;
      ring_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      model_q <= model;
      time_q  <= time_d;
      date_q  <= date_d;
      state_q <= state_d;
      ring_q  <= ring_d;
    end
  end

  assign time_num   = time_q;
  assign date_num   = date_q;
  assign sec_tick   = tick;
  assign alarm_ring = (state_q == StRing);

  // The carry out of the year is deliberately dropped: 99 wraps to 00.
  logic unused_year_carry;
  assign unused_year_carry = c_year;

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Randomized and directed bench for rtc_timekeeper against a seconds-of-day calendar model.
module tb_rtc_timekeeper;

  localparam int N    = 10;
  localparam int RING = 3;

  logic        clk;
  logic        rst_n;
  logic [1:0]  model;
  logic [23:0] adjust_time_num;
  logic [23:0] adjust_date_num;
  logic [15:0] adjust_clock_num;
  logic        alarm_stop;
  logic [23:0] time_num;
  logic [23:0] date_num;
  logic        sec_tick;
  logic        alarm_ring;

  rtc_timekeeper #(
    .CLK_FREQ_HZ    (N),
    .ALARM_RING_SEC (RING)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .model            (model),
    .adjust_time_num  (adjust_time_num),
    .adjust_date_num  (adjust_date_num),
    .adjust_clock_num (adjust_clock_num),
    .alarm_stop       (alarm_stop),
    .time_num         (time_num),
    .date_num         (date_num),
    .sec_tick         (sec_tick),
    .alarm_ring       (alarm_ring)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference state: time as seconds of day, date as plain integers.
  int m_secs, m_y, m_mo, m_d, m_phase, m_rcnt;
  int m_prev;
  bit m_ring;

  function automatic logic [7:0] b2(input int v);
    return 8'(((v / 10) % 10) * 16 + (v % 10));
  endfunction

  function automatic int d2(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic int dim(input int mo, input int y);
    if (mo == 2) return (y % 4 == 0) ? 29 : 28;
    if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
    return 31;
  endfunction

  function automatic logic [23:0] exp_time();
    return {b2(m_secs / 3600), b2((m_secs / 60) % 60), b2(m_secs % 60)};
  endfunction

  function automatic logic [23:0] exp_date();
    return {b2(m_y), b2(m_mo), b2(m_d)};
  endfunction

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_secs = 0; m_y = 0; m_mo = 1; m_d = 1;
    m_phase = 0; m_prev = 0; m_ring = 0; m_rcnt = 0;
  endtask

  // Per-cycle compare at the falling edge, then advance the model to the next rising edge.
  always @(negedge clk) begin
    bit is_load, e_tick, match;
    int mo, dd, ns;
    if (!rst_n) begin
      model_reset();
      chk("rst_time", time_num, exp_time());
      chk("rst_date", date_num, exp_date());
      chk("rst_tick", {23'd0, sec_tick}, 24'd0);
      chk("rst_ring", {23'd0, alarm_ring}, 24'd0);
    end else begin
      is_load = (m_prev == 3) && (model != 2'b11);
      e_tick  = (m_phase == N - 1) && (model != 2'b11) && !is_load;
      chk("cyc_time", time_num, exp_time());
      chk("cyc_date", date_num, exp_date());
      chk("cyc_tick", {23'd0, sec_tick}, {23'd0, e_tick});
      chk("cyc_ring", {23'd0, alarm_ring}, {23'd0, m_ring});

      match = 0;
      if (is_load) begin
        m_secs = d2(adjust_time_num[23:16]) * 3600 + d2(adjust_time_num[15:8]) * 60
               + d2(adjust_time_num[7:0]);
        m_y = d2(adjust_date_num[23:16]);
        mo  = d2(adjust_date_num[15:8]);
        dd  = d2(adjust_date_num[7:0]);
        if (mo == 0) mo = 1;
        if (mo > 12) mo = 12;
        if (dd == 0) dd = 1;
        if (dd > dim(mo, m_y)) dd = dim(mo, m_y);
        m_mo = mo;
        m_d  = dd;
      end else if (e_tick) begin
        ns = m_secs + 1;
        if (ns == 86400) begin
          ns = 0;
          m_d++;
          if (m_d > dim(m_mo, m_y)) begin
            m_d = 1;
            m_mo++;
            if (m_mo > 12) begin
              m_mo = 1;
              m_y  = (m_y + 1) % 100;
            end
          end
        end
        m_secs = ns;
        match = (ns == d2(adjust_clock_num[15:8]) * 3600 + d2(adjust_clock_num[7:0]) * 60);
      end

      if (alarm_stop) begin
        m_ring = 0; m_rcnt = 0;
      end else if (match) begin
        m_ring = 1; m_rcnt = RING;
      end else if (e_tick && m_ring) begin
        m_rcnt--;
        if (m_rcnt <= 0) begin
          m_ring = 0; m_rcnt = 0;
        end
      end

      m_phase = (model == 2'b11 || is_load || m_phase == N - 1) ? 0 : m_phase + 1;
      m_prev  = int'(model);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [23:0] t, input logic [23:0] d, input int hold,
                         input logic [1:0] after);
    model = 2'b11;
    step(hold);
    adjust_time_num = t;
    adjust_date_num = d;
    model = after;
    step(1);
  endtask

  function automatic logic [23:0] rand_time();
    int s;
    if ($urandom_range(0, 1) == 1) s = 86400 - 1 - int'($urandom_range(0, 20));
    else s = int'($urandom_range(0, 86399));
    return {b2(s / 3600), b2((s / 60) % 60), b2(s % 60)};
  endfunction

  initial begin
    logic [23:0] frozen;
    int ns;
    rst_n = 1'b0;
    model = 2'b00;
    adjust_time_num  = 24'h120000;
    adjust_date_num  = 24'h000101;
    adjust_clock_num = 16'h1200;
    alarm_stop = 1'b0;
    model_reset();
    step(2);
    chk("reset_time", time_num, 24'h000000);
    chk("reset_date", date_num, 24'h000101);
    chk("reset_ring", {23'd0, alarm_ring}, 24'd0);
    rst_n = 1'b1;

    // First second after reset.
    step(9);
    chk("first_tick", {23'd0, sec_tick}, 24'd1);
    step(1);
    chk("first_sec", time_num, 24'h000001);
    chk("first_sec_model", exp_time(), 24'h000001);

    // Full calendar rollover.
    do_load(24'h235959, 24'h991231, 2, 2'b00);
    step(10);
    chk("roll_time", time_num, 24'h000000);
    chk("roll_date", date_num, 24'h000101);
    chk("roll_date_model", exp_date(), 24'h000101);

    // Leap and non-leap February.
    do_load(24'h235959, 24'h240228, 2, 2'b00);
    step(10);
    chk("leap_date", date_num, 24'h240229);
    do_load(24'h235959, 24'h230228, 2, 2'b00);
    step(10);
    chk("nonleap_date", date_num, 24'h230301);
    chk("nonleap_model", exp_date(), 24'h230301);

    // Sanitize on load.
    do_load(24'h000000, 24'h250431, 2, 2'b00);
    chk("san_day", date_num, 24'h250430);
    do_load(24'h000000, 24'h251300, 2, 2'b00);
    chk("san_month", date_num, 24'h251201);
    chk("san_month_model", exp_date(), 24'h251201);

    // Alarm ring for three ticks.
    adjust_clock_num = 16'h0700;
    do_load(24'h065959, 24'h250101, 2, 2'b00);
    step(10);
    chk("alarm_time", time_num, 24'h070000);
    chk("alarm_on", {23'd0, alarm_ring}, 24'd1);
    step(20);
    chk("alarm_still", {23'd0, alarm_ring}, 24'd1);
    step(10);
    chk("alarm_end_time", time_num, 24'h070003);
    chk("alarm_off", {23'd0, alarm_ring}, 24'd0);

    // Alarm stop mid-ring.
    do_load(24'h065959, 24'h250101, 2, 2'b00);
    step(13);
    chk("stop_pre", {23'd0, alarm_ring}, 24'd1);
    alarm_stop = 1'b1;
    step(1);
    alarm_stop = 1'b0;
    chk("stop_off", {23'd0, alarm_ring}, 24'd0);

    // Reset mid-ring.
    do_load(24'h065959, 24'h250101, 2, 2'b00);
    step(12);
    rst_n = 1'b0;
    #1;
    chk("rst_ring_off", {23'd0, alarm_ring}, 24'd0);
    chk("rst_ring_time", time_num, 24'h000000);
    step(2);
    rst_n = 1'b1;

    // Calibrate hold mid-second, then reload restarts the prescaler.
    step(14);
    model = 2'b11;
    frozen = time_num;
    for (int i = 0; i < 50; i++) begin
      chk("hold_tick", {23'd0, sec_tick}, 24'd0);
      chk("hold_time", time_num, frozen);
      step(1);
    end
    adjust_time_num = 24'h101010;
    adjust_date_num = 24'h240615;
    model = 2'b00;
    step(1);
    chk("exit_load", time_num, 24'h101010);
    step(8);
    chk("exit_no_tick", {23'd0, sec_tick}, 24'd0);
    step(1);
    chk("exit_tick", {23'd0, sec_tick}, 24'd1);

    // Randomized phase; the per-cycle compare does the checking.
    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          if ($urandom_range(0, 1) == 1) begin
            ns = (d2(adjust_time_num[23:16]) * 60 + d2(adjust_time_num[15:8]) + 1) % 1440;
            adjust_clock_num = {b2(ns / 60), b2(ns % 60)};
          end
          do_load(rand_time(),
                  {b2(int'($urandom_range(0, 99))), b2(int'($urandom_range(0, 19))),
                   b2(int'($urandom_range(0, 39)))},
                  int'($urandom_range(1, 30)), 2'($urandom_range(0, 2)));
          step(int'($urandom_range(1, 40)));
        end
        3: begin
          ns = (m_secs / 60 + 1) % 1440;
          adjust_clock_num = {b2(ns / 60), b2(ns % 60)};
          step(N * int'($urandom_range(1, 70)));
        end
        4: begin
          alarm_stop = 1'b1;
          step(1);
          alarm_stop = 1'b0;
          step(int'($urandom_range(1, 20)));
        end
        default: begin
          model = 2'($urandom_range(0, 2));
          adjust_time_num = rand_time();
          step(int'($urandom_range(1, 40)));
        end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
